uv_rst_ctrl: RTL and testbench
==============================

// Module: uv_rst_ctrl
// PURPOSE
//   System reset controller downstream of the watchdog. Merges the watchdog reset
//   (wdt_rst_n), a software reset pulse and a debug reset level into one stretched,
//   glitch-free, synchronous-deassert system reset (sys_rst_n).
//   Keeps a sticky reset-cause record that survives system reset; only the primary
//   reset clears it.
// PARAMETERS
//   RST_CYCLES   16   sys_rst_n low-hold length in clk cycles; legal range 1..2**CNT_W
//   CNT_W        8    width of the hold counter
//   SYNC_STAGES  2    synchroniser depth for wdt_rst_n; minimum 2
// PORTS
//   clk          in   1      single clock; all logic on its rising edge
//   rst          in   1      asynchronous, active-high primary (power-on) reset
//   wdt_rst_n    in   1      watchdog reset request, active-low level; may be asynchronous
//   sw_rst_req   in   1      software reset request, 1-cycle pulse, synchronous
//   dbg_rst_req  in   1      debugger reset request, active-high level, synchronous
//   cause_clr    in   1      1-cycle pulse; clears rst_cause (honoured in IDLE only)
//   sys_rst_n    out  1      stretched system reset, active-low, registered
//   rst_cause    out  4      sticky cause: [0] POR, [1] WDT, [2] SW, [3] DBG
//   rst_busy     out  1      high while state != IDLE
// BEHAVIOUR
//   Reset (rst=1, async) drives the following values:
//     state=HOLD, cnt=RST_CYCLES-1, sys_rst_n=0, rst_busy=1, rst_cause=4'b0001.
//     All synchroniser flops = 1.
//   Sync: wdt_rst_n passes SYNC_STAGES flops to give wdt_s; all later logic uses wdt_s.
//   Trigger vector: trg = {dbg_rst_req, sw_rst_req, ~wdt_s}; any = |trg.
//   FSM states, all registered:
//     IDLE: sys_rst_n=1.
//       If any: next state HOLD, cnt<=RST_CYCLES-1, sys_rst_n<=0, rst_cause<={trg,1'b0}.
//         The cause write replaces the old value, so simultaneous sources all set.
//       Else if cause_clr: rst_cause<=0.
//       A trigger beats cause_clr in the same cycle.
//     HOLD: sys_rst_n=0. cnt decrements every cycle.
//       When cnt==0: go to WAIT if (~wdt_s | dbg_rst_req), else go to IDLE.
//       HOLD therefore lasts exactly RST_CYCLES cycles.
//     WAIT: sys_rst_n=0. Stay while (~wdt_s | dbg_rst_req).
//       Once both are inactive, go to IDLE.
//   sys_rst_n rises on the same edge the FSM enters IDLE, i.e. deassertion is synchronous.
//   sys_rst_n falls on the edge after a trigger is seen in IDLE.
//   Latency from a wdt_rst_n fall to the sys_rst_n fall is SYNC_STAGES+1 clk edges.
//   Latency from a sw_rst_req or dbg_rst_req sample to the sys_rst_n fall is 1 edge.
//   In HOLD and WAIT:
//     sw_rst_req pulses are ignored (dropped, not queued).
//     cause_clr is ignored.
//     rst_cause is not modified.
//   RST_CYCLES==1: HOLD lasts one cycle.
//   The counter never wraps; cnt is reloaded only on entry to HOLD.
//   rst asserted mid-HOLD or mid-WAIT restarts the sequence from the reset values above.
//   No combinational path from any input to any output.
// TESTING
//   1. POR: release rst. sys_rst_n stays 0 for 16 clks, then rises.
//      rst_cause==4'b0001 and rst_busy falls on the same edge.
//   2. WDT pulse: drop wdt_rst_n for 3 clks. sys_rst_n falls 3 edges later and stays low 16 clks.
//      rst_cause==4'b0010.
//   3. Long WDT: hold wdt_rst_n low for 40 clks. sys_rst_n stays low until 1 edge after wdt_s rises.
//      The FSM passes HOLD then WAIT.
//   4. Simultaneous sources: sw_rst_req and dbg_rst_req in the same cycle give rst_cause==4'b1100.
//      A second sw pulse during HOLD causes no extension and no cause change.
//   5. cause_clr in IDLE gives rst_cause==0.
//      cause_clr and sw_rst_req in the same cycle give rst_cause==4'b0100 and a reset.
//   6. Assert rst at HOLD cnt==5: sys_rst_n stays 0.
//      After release, a full 16-clk hold follows and rst_cause==4'b0001.

Source files
------------

// File: rtl/uv_rst_ctrl.sv
// uv_rst_ctrl: merges watchdog, software and debug resets into one stretched system reset with a sticky cause record
module uv_rst_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdt_rst_n,
    input  logic       sw_rst_req,
    input  logic       dbg_rst_req,
    input  logic       cause_clr,
    output logic       sys_rst_n,
    output logic [3:0] rst_cause,
    output logic       rst_busy
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   rst_busy_q, rst_busy_d;
    logic [3:0]             rst_cause_q, rst_cause_d;
    logic                   wdt_s, ext, any;
    logic [2:0]             trg;
    // synchroniser shift; resets to the inactive level so POR does not look like a watchdog hit
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], wdt_rst_n};
    // trigger decode; ext holds the reset past the counted window
    always_comb begin
        wdt_s = sync_q[SYNC_STAGES-1];
        trg   = {dbg_rst_req, sw_rst_req, ~wdt_s};
        any   = |trg;
        ext   = ~wdt_s | dbg_rst_req;
    end
    // next state, hold counter and cause record; outputs registered from the next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_cause_d = rst_cause_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = HOLD;
                    cnt_d       = CNT_INIT;
                    rst_cause_d = {trg, 1'b0};
                end else if (cause_clr) begin
                    rst_cause_d = '0;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = ext ? WAIT : IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WAIT:    state_d = ext ? WAIT : IDLE;
            default: state_d = HOLD;
        endcase
        sys_rst_n_d = (state_d == IDLE);
        rst_busy_d  = (state_d != IDLE);
    end
    // state registers; primary reset restarts the full hold sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            cnt_q       <= CNT_INIT;
            sync_q      <= '1;
            sys_rst_n_q <= 1'b0;
            rst_busy_q  <= 1'b1;
            rst_cause_q <= 4'b0001;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            sys_rst_n_q <= sys_rst_n_d;
            rst_busy_q  <= rst_busy_d;
            rst_cause_q <= rst_cause_d;
        end
    end
    assign sys_rst_n = sys_rst_n_q;
    assign rst_busy  = rst_busy_q;
    assign rst_cause = rst_cause_q;
endmodule

// File: tb/tb_uv_rst_ctrl.sv
// tb_uv_rst_ctrl: directed checks of the reset controller, plus a RST_CYCLES=1 instance
module tb_uv_rst_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wdt_rst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       dbg_rst_req = 1'b0;
    logic       cause_clr = 1'b0;
    logic       sys_rst_n, rst_busy;
    logic [3:0] rst_cause;
    logic       s1_n, b1;
    logic [3:0] c1;
    int         n_cmp = 0;
    int         n_err = 0;

    uv_rst_ctrl dut (
        .clk(clk), .rst(rst), .wdt_rst_n(wdt_rst_n), .sw_rst_req(sw_rst_req),
        .dbg_rst_req(dbg_rst_req), .cause_clr(cause_clr),
        .sys_rst_n(sys_rst_n), .rst_cause(rst_cause), .rst_busy(rst_busy)
    );

    uv_rst_ctrl #(.RST_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wdt_rst_n(wdt_rst_n), .sw_rst_req(sw_rst_req),
        .dbg_rst_req(dbg_rst_req), .cause_clr(cause_clr),
        .sys_rst_n(s1_n), .rst_cause(c1), .rst_busy(b1)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. power-on reset
        cyc(2);
        chk("por_sys_in_rst", {3'b0, sys_rst_n}, 4'h0);
        chk("por_busy_in_rst", {3'b0, rst_busy}, 4'h1);
        chk("por_cause_in_rst", rst_cause, 4'b0001);
        rst = 1'b0;
        cyc(1);
        chk("rc1_por_sys", {3'b0, s1_n}, 4'h1);
        cyc(14);
        chk("por_sys_edge15", {3'b0, sys_rst_n}, 4'h0);
        chk("por_busy_edge15", {3'b0, rst_busy}, 4'h1);
        cyc(1);
        chk("por_sys_edge16", {3'b0, sys_rst_n}, 4'h1);
        chk("por_busy_edge16", {3'b0, rst_busy}, 4'h0);
        chk("por_cause", rst_cause, 4'b0001);
        // 2. short watchdog pulse
        wdt_rst_n = 1'b0;
        cyc(2);
        chk("wdt_sys_edge2", {3'b0, sys_rst_n}, 4'h1);
        cyc(1);
        chk("wdt_sys_edge3", {3'b0, sys_rst_n}, 4'h0);
        chk("wdt_busy", {3'b0, rst_busy}, 4'h1);
        chk("wdt_cause", rst_cause, 4'b0010);
        wdt_rst_n = 1'b1;
        cyc(15);
        chk("wdt_hold_end_low", {3'b0, sys_rst_n}, 4'h0);
        cyc(1);
        chk("wdt_release", {3'b0, sys_rst_n}, 4'h1);
        chk("wdt_busy_off", {3'b0, rst_busy}, 4'h0);
        // 3. long watchdog: HOLD then WAIT
        wdt_rst_n = 1'b0;
        cyc(3);
        chk("lwdt_sys_fall", {3'b0, sys_rst_n}, 4'h0);
        cyc(37);
        chk("lwdt_wait_low", {3'b0, sys_rst_n}, 4'h0);
        chk("lwdt_wait_busy", {3'b0, rst_busy}, 4'h1);
        wdt_rst_n = 1'b1;
        cyc(2);
        chk("lwdt_ws_rise_low", {3'b0, sys_rst_n}, 4'h0);
        cyc(1);
        chk("lwdt_release", {3'b0, sys_rst_n}, 4'h1);
        chk("lwdt_cause", rst_cause, 4'b0010);
        // 4. simultaneous sw + dbg, then a dropped sw pulse in HOLD
        sw_rst_req = 1'b1;
        dbg_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        dbg_rst_req = 1'b0;
        chk("sim_sys_fall", {3'b0, sys_rst_n}, 4'h0);
        chk("sim_cause", rst_cause, 4'b1100);
        cyc(4);
        sw_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        chk("sim_sw_in_hold_cause", rst_cause, 4'b1100);
        cyc(10);
        chk("sim_hold_end_low", {3'b0, sys_rst_n}, 4'h0);
        cyc(1);
        chk("sim_no_extend", {3'b0, sys_rst_n}, 4'h1);
        chk("sim_cause_kept", rst_cause, 4'b1100);
        // 5. cause clear in IDLE, clear vs trigger, clear ignored in HOLD
        cause_clr = 1'b1;
        cyc(1);
        cause_clr = 1'b0;
        chk("clr_cause", rst_cause, 4'b0000);
        chk("clr_sys", {3'b0, sys_rst_n}, 4'h1);
        cause_clr = 1'b1;
        sw_rst_req = 1'b1;
        cyc(1);
        cause_clr = 1'b0;
        sw_rst_req = 1'b0;
        chk("clrsw_cause", rst_cause, 4'b0100);
        chk("clrsw_sys", {3'b0, sys_rst_n}, 4'h0);
        chk("rc1_sw_fall", {3'b0, s1_n}, 4'h0);
        cyc(1);
        chk("rc1_sw_rise", {3'b0, s1_n}, 4'h1);
        cyc(2);
        cause_clr = 1'b1;
        cyc(1);
        cause_clr = 1'b0;
        chk("clr_in_hold_ignored", rst_cause, 4'b0100);
        cyc(11);
        chk("clrsw_hold_end_low", {3'b0, sys_rst_n}, 4'h0);
        cyc(1);
        chk("clrsw_release", {3'b0, sys_rst_n}, 4'h1);
        // 6. primary reset mid-HOLD at cnt==5
        sw_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_sys", {3'b0, sys_rst_n}, 4'h0);
        chk("mid_rst_cause", rst_cause, 4'b0001);
        rst = 1'b0;
        cyc(15);
        chk("mid_rst_hold_low", {3'b0, sys_rst_n}, 4'h0);
        cyc(1);
        chk("mid_rst_release", {3'b0, sys_rst_n}, 4'h1);
        chk("mid_rst_cause_end", rst_cause, 4'b0001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
